// File: rtl/safe_pkg.sv
// Shared types and constants for the safe unlock sequencer.
// The PROG state exists only when SAFE_REPROGRAM_EN is defined.
package safe_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t MAX_DIGIT = digit_t'(9);

`ifdef SAFE_REPROGRAM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4,
        PROG    = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_e;
`endif

endpackage

// File: rtl/safe_timer.sv
// Loadable down-counter with a zero flag; shared by the OPEN hold and LOCKOUT windows.
module safe_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && !zero_c) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/safe_unlock_sequencer.sv
// Digital safe controller: code entry, compare, open hold window, failed-attempt lockout.
// Define SAFE_REPROGRAM_EN to add the prog input and the PROG (code rewrite) state.
module safe_unlock_sequencer
    import safe_pkg::*;
#(
    parameter int unsigned               CODE_LEN    = 4,
    parameter int unsigned               MAX_FAILS   = 3,
    parameter int unsigned               LOCK_CYCLES = 1000,
    parameter int unsigned               OPEN_CYCLES = 500,
    parameter logic [CODE_LEN*DIGIT_W-1:0] RESET_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  digit_t     digit,
    input  logic       digit_vld,
    input  logic       clear,
    input  logic       relock,
`ifdef SAFE_REPROGRAM_EN
    input  logic       prog,
`endif
    output logic       locked,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] entry_cnt,
    output logic [3:0] fail_cnt
);

    localparam int unsigned CODE_W    = CODE_LEN * DIGIT_W;
    localparam int unsigned TMR_MAX   = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TMR_W     = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
    localparam logic [2:0]  LAST_IDX  = 3'(CODE_LEN - 1);
    localparam logic [3:0]  FAIL_LAST = 4'(MAX_FAILS - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   entry_q, entry_d;
    logic [CODE_W-1:0]   shifted_c;
    logic [CODE_W-1:0]   code_cur;
    logic [2:0]          ecnt_d;
    logic [3:0]          fcnt_d;
    logic                unlocked_d, alarm_d;
    logic                digit_ok_c;
    logic                tmr_load, tmr_dec, tmr_zero_c;
    logic [TMR_W-1:0]    tmr_val;

    // Digits above 9 are treated as if no strobe happened.
    assign digit_ok_c = digit_vld && (digit <= MAX_DIGIT);
    // New digit enters the LS nibble so the first digit ends up in the MS nibble.
    assign shifted_c  = CODE_W'({entry_q, digit});

`ifdef SAFE_REPROGRAM_EN
    logic [CODE_W-1:0] code_q, code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= RESET_CODE;
        end else begin
            code_q <= code_d;
        end
    end

    assign code_cur = code_q;
`else
    assign code_cur = RESET_CODE;
`endif

    safe_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            entry_q   <= '0;
            entry_cnt <= '0;
            fail_cnt  <= '0;
            locked    <= 1'b1;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            entry_cnt <= ecnt_d;
            fail_cnt  <= fcnt_d;
            locked    <= ~unlocked_d;
            unlocked  <= unlocked_d;
            alarm     <= alarm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        entry_d  = entry_q;
        ecnt_d   = entry_cnt;
        fcnt_d   = fail_cnt;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
`ifdef SAFE_REPROGRAM_EN
        code_d   = code_q;
`endif

        case (state_q)
            IDLE: begin
                if (!clear && digit_ok_c) begin
                    entry_d = shifted_c;
                    ecnt_d  = 3'd1;
                    state_d = (CODE_LEN == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (digit_ok_c) begin
                    entry_d = shifted_c;
                    ecnt_d  = entry_cnt + 3'd1;
                    if (entry_cnt == LAST_IDX) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                entry_d = '0;
                ecnt_d  = '0;
                if (entry_q == code_cur) begin
                    fcnt_d   = '0;
                    state_d  = OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(OPEN_CYCLES - 1);
                end else begin
                    if (fail_cnt < 4'(MAX_FAILS)) begin
                        fcnt_d = fail_cnt + 4'd1;
                    end
                    if (fail_cnt >= FAIL_LAST) begin
                        state_d  = LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                if (relock || tmr_zero_c) begin
                    state_d = IDLE;
`ifdef SAFE_REPROGRAM_EN
                end else if (prog) begin
                    state_d = PROG;
                    entry_d = '0;
                    ecnt_d  = '0;
`endif
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            LOCKOUT: begin
                // Only timer expiry (or reset) leaves lockout.
                if (tmr_zero_c) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
`ifdef SAFE_REPROGRAM_EN
            PROG: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (digit_ok_c) begin
                    entry_d = shifted_c;
                    ecnt_d  = entry_cnt + 3'd1;
                    if (entry_cnt == LAST_IDX) begin
                        code_d  = shifted_c;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every return to IDLE starts a fresh attempt.
        if (state_d == IDLE) begin
            entry_d = '0;
            ecnt_d  = '0;
        end

`ifdef SAFE_REPROGRAM_EN
        unlocked_d = (state_d == OPEN) || (state_d == PROG);
`else
        unlocked_d = (state_d == OPEN);
`endif
        alarm_d    = (state_d == LOCKOUT);
    end

endmodule

// File: tb/tb_safe_unlock_sequencer.sv
// Directed bench for safe_unlock_sequencer: vector table plus hand sequences for timed windows.
module tb_safe_unlock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] digit;
    logic       digit_vld;
    logic       clear;
    logic       relock;
`ifdef SAFE_REPROGRAM_EN
    logic       prog;
`endif
    logic       locked;
    logic       unlocked;
    logic       alarm;
    logic [2:0] entry_cnt;
    logic [3:0] fail_cnt;

    int checks   = 0;
    int failures = 0;
    int n;
    int bad;
    int a_end, b_end, c_end;

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic       c;
        logic       r;
        logic       lk;
        logic       un;
        logic       al;
        logic [2:0] ec;
        logic [3:0] fc;
    } vec_t;

    vec_t vecs [0:63];
    int   nv = 0;

    safe_unlock_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit     (digit),
        .digit_vld (digit_vld),
        .clear     (clear),
        .relock    (relock),
`ifdef SAFE_REPROGRAM_EN
        .prog      (prog),
`endif
        .locked    (locked),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .entry_cnt (entry_cnt),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] d, input logic v, input logic c, input logic r,
                       input logic lk, input logic un, input logic al,
                       input logic [2:0] ec, input logic [3:0] fc);
        vecs[nv] = '{d, v, c, r, lk, un, al, ec, fc};
        nv++;
    endtask

    task automatic idle_inputs();
        digit     = 4'd0;
        digit_vld = 1'b0;
        clear     = 1'b0;
        relock    = 1'b0;
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            digit     = vecs[i].d;
            digit_vld = vecs[i].v;
            clear     = vecs[i].c;
            relock    = vecs[i].r;
            tick();
            check($sformatf("vec%0d locked", i),    locked,    vecs[i].lk);
            check($sformatf("vec%0d unlocked", i),  unlocked,  vecs[i].un);
            check($sformatf("vec%0d alarm", i),     alarm,     vecs[i].al);
            check($sformatf("vec%0d entry_cnt", i), entry_cnt, vecs[i].ec);
            check($sformatf("vec%0d fail_cnt", i),  fail_cnt,  vecs[i].fc);
        end
        idle_inputs();
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) begin
            digit     = code[15-4*i -: 4];
            digit_vld = 1'b1;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
`ifdef SAFE_REPROGRAM_EN
        prog = 1'b0;
`endif
        rst_n = 1'b0;

        // Section A: clear mid-entry, clear+strobe, invalid digits, then correct code.
        add(4'd1, 1, 0, 0, 1, 0, 0, 3'd1, 4'd0);
        add(4'd2, 1, 0, 0, 1, 0, 0, 3'd2, 4'd0);
        add(4'd0, 0, 1, 0, 1, 0, 0, 3'd0, 4'd0);
        add(4'd1, 1, 0, 0, 1, 0, 0, 3'd1, 4'd0);
        add(4'hA, 1, 0, 0, 1, 0, 0, 3'd1, 4'd0);
        add(4'd2, 1, 0, 0, 1, 0, 0, 3'd2, 4'd0);
        add(4'hF, 1, 0, 0, 1, 0, 0, 3'd2, 4'd0);
        add(4'd3, 1, 0, 0, 1, 0, 0, 3'd3, 4'd0);
        add(4'd4, 1, 1, 0, 1, 0, 0, 3'd0, 4'd0);
        add(4'd1, 1, 0, 0, 1, 0, 0, 3'd1, 4'd0);
        add(4'd2, 1, 0, 0, 1, 0, 0, 3'd2, 4'd0);
        add(4'd3, 1, 0, 0, 1, 0, 0, 3'd3, 4'd0);
        add(4'hE, 1, 0, 0, 1, 0, 0, 3'd3, 4'd0);
        add(4'd4, 1, 0, 0, 1, 0, 0, 3'd4, 4'd0);
        add(4'd0, 0, 0, 0, 0, 1, 0, 3'd0, 4'd0);
        a_end = nv;
        // Section B: wrong code three times leads to lockout.
        for (int k = 0; k < 3; k++) begin
            add(4'd1, 1, 0, 0, 1, 0, 0, 3'd1, 4'(k));
            add(4'd2, 1, 0, 0, 1, 0, 0, 3'd2, 4'(k));
            add(4'd3, 1, 0, 0, 1, 0, 0, 3'd3, 4'(k));
            add(4'd5, 1, 0, 0, 1, 0, 0, 3'd4, 4'(k));
            if (k < 2) add(4'd0, 0, 0, 0, 1, 0, 0, 3'd0, 4'(k + 1));
            else       add(4'd0, 0, 0, 0, 1, 0, 1, 3'd0, 4'd3);
        end
        b_end = nv;
        // Section C: correct code after lockout expires.
        add(4'd1, 1, 0, 0, 1, 0, 0, 3'd1, 4'd0);
        add(4'd2, 1, 0, 0, 1, 0, 0, 3'd2, 4'd0);
        add(4'd3, 1, 0, 0, 1, 0, 0, 3'd3, 4'd0);
        add(4'd4, 1, 0, 0, 1, 0, 0, 3'd4, 4'd0);
        add(4'd0, 0, 0, 0, 0, 1, 0, 3'd0, 4'd0);
        c_end = nv;

        repeat (2) @(posedge clk);
        #1;
        check("rst locked",    locked,    1'b1);
        check("rst unlocked",  unlocked,  1'b0);
        check("rst alarm",     alarm,     1'b0);
        check("rst entry_cnt", entry_cnt, 3'd0);
        check("rst fail_cnt",  fail_cnt,  4'd0);
        rst_n = 1'b1;
        tick();

        apply(0, a_end);

        // Open window length: first OPEN sample already seen above.
        n = unlocked ? 1 : 0;
        while (unlocked && n < 600) begin
            tick();
            if (unlocked) n++;
        end
        check("open_len", n, 500);
        check("open_end locked", locked, 1'b1);

        apply(a_end, b_end);

        // Lockout: hammer all inputs, expect them ignored for the full window.
        n   = alarm ? 1 : 0;
        bad = 0;
        while (alarm && n < 1100) begin
            digit     = 4'(n % 10);
            digit_vld = 1'b1;
            clear     = n[0];
            relock    = n[1];
            tick();
            if (alarm) begin
                n++;
                if (entry_cnt != 3'd0 || fail_cnt != 4'd3 || !locked) bad++;
            end
        end
        idle_inputs();
        check("lockout_len", n, 1000);
        check("lockout ignored inputs", bad, 0);
        check("post_lockout alarm",     alarm,     1'b0);
        check("post_lockout fail_cnt",  fail_cnt,  4'd0);
        check("post_lockout locked",    locked,    1'b1);
        check("post_lockout entry_cnt", entry_cnt, 3'd0);

        apply(b_end, c_end);

        // Relock asserted in the tenth OPEN cycle.
        repeat (9) tick();
        check("open_cycle10 unlocked", unlocked, 1'b1);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        check("relock locked",   locked,   1'b1);
        check("relock unlocked", unlocked, 1'b0);

        // Asynchronous reset in the middle of lockout.
        enter_code(16'h1235);
        enter_code(16'h1235);
        enter_code(16'h1235);
        check("lockout2 alarm",    alarm,    1'b1);
        check("lockout2 fail_cnt", fail_cnt, 4'd3);
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst alarm",     alarm,     1'b0);
        check("async_rst fail_cnt",  fail_cnt,  4'd0);
        check("async_rst locked",    locked,    1'b1);
        check("async_rst unlocked",  unlocked,  1'b0);
        check("async_rst entry_cnt", entry_cnt, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("after_rst alarm", alarm, 1'b0);
        enter_code(16'h1234);
        check("after_rst unlock", unlocked, 1'b1);

`ifdef SAFE_REPROGRAM_EN
        prog = 1'b1;
        tick();
        prog = 1'b0;
        check("prog entry_cnt", entry_cnt, 3'd0);
        digit_vld = 1'b1;
        digit = 4'd9; tick(); check("prog d1 entry_cnt", entry_cnt, 3'd1);
        digit = 4'd8; tick(); check("prog d2 entry_cnt", entry_cnt, 3'd2);
        digit = 4'd7; tick(); check("prog d3 entry_cnt", entry_cnt, 3'd3);
        digit = 4'd6; tick();
        idle_inputs();
        check("prog done entry_cnt", entry_cnt, 3'd0);
        check("prog done locked",    locked,    1'b1);
        enter_code(16'h1234);
        check("old code fail_cnt", fail_cnt, 4'd1);
        check("old code locked",   locked,   1'b1);
        enter_code(16'h9876);
        check("new code unlocked", unlocked, 1'b1);
        check("new code fail_cnt", fail_cnt, 4'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/safe_unlock_sequencer.md
Name: safe_unlock_sequencer

Overview:
- Sequential controller for the digital safe. Collects a multi-digit code from a 4-bit digit input using a valid strobe.
- Compares the collected code against a stored code, then drives lock/unlock indicators.
- Counts failed attempts and enforces a timed lockout. Holds the safe open for a timed window, then relocks.
- Sits between the keypad/switch front end and the lock actuator/LED outputs.

Parameters:
- CODE_LEN, 4, number of 4-bit digits per code (legal range 1..8).
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (legal range 1..15).
- LOCK_CYCLES, 1000, lockout duration in clk cycles (legal range ≥1).
- OPEN_CYCLES, 500, unlocked hold time in clk cycles (legal range ≥1).
- RESET_CODE, 16'h1234, stored code loaded at reset. Width is CODE_LEN*4. Digit 0 is in the MS nibble.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- digit  in  4  entered digit, legal 0..9
- digit_vld  in  1  one-cycle strobe; digit sampled when high
- clear  in  1  abort current entry
- relock  in  1  force relock while OPEN
- locked  out  1  L0 indicator, safe closed
- unlocked  out  1  L1 indicator, safe open
- alarm  out  1  high during lockout
- entry_cnt  out  3  digits collected so far in the current attempt
- fail_cnt  out  4  consecutive failed attempts

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state is cleared immediately on assertion; release is sampled on clk.
- Reset values: state=IDLE, locked=1, unlocked=0, alarm=0, entry_cnt=0, fail_cnt=0, stored code=RESET_CODE.
- Outputs are registered. locked and unlocked are always complementary.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- IDLE: on digit_vld with digit ≤9, shift the digit into the entry register, set entry_cnt=1, go to ENTRY.
- Digits >9 are ignored in every state and count as nothing.
- ENTRY: each valid digit shifts in and increments entry_cnt.
  - When entry_cnt reaches CODE_LEN, go to CHECK on the next edge.
  - clear returns to IDLE with entry_cnt=0. The attempt is not counted as a failure.
  - clear wins over a simultaneous digit_vld.
- CHECK: exactly one cycle. The compare is registered. Total latency from the final digit_vld to the unlocked rise is 2 cycles.
  - On match: fail_cnt=0, go to OPEN.
  - On mismatch: fail_cnt+1. If the new value equals MAX_FAILS, go to LOCKOUT; otherwise go to IDLE.
- OPEN: unlocked=1, locked=0.
  - A down-counter is loaded with OPEN_CYCLES-1 on entry. At 0, or on relock, go to IDLE.
  - Digits are ignored while OPEN.
- LOCKOUT: alarm=1, locked=1.
  - A counter is loaded with LOCK_CYCLES-1. At 0, go to IDLE with fail_cnt=0 and alarm=0.
  - digit_vld, clear and relock are all ignored. Reset is the only early exit.
- fail_cnt saturates at MAX_FAILS and never wraps.
- Entry register is cleared on every return to IDLE.
- Reset mid-entry or mid-lockout: state returns to IDLE and fail_cnt clears. Lockout cannot persist across reset.

Optional Feature:
- Macro: SAFE_REPROGRAM_EN.
- When defined:
  - Extra input prog (1 bit) is added.
  - In OPEN, prog high for one cycle enters state PROG and restarts entry_cnt at 0.
  - In PROG, CODE_LEN valid digits overwrite the stored code, then the block goes to IDLE.
  - clear in PROG aborts and keeps the old code.
  - The OPEN timer does not run in PROG.
- When undefined: no prog port and no PROG state. The stored code is the constant RESET_CODE.

Decomposition:
- Package safe_pkg holds:
  - state enum typedef (state_e)
  - DIGIT_W=4
  - MAX_DIGIT=9
  - digit typedef
- One sub-module, safe_timer: a loadable down-counter with a zero flag. The controller uses one instance, reloaded for OPEN and for LOCKOUT. Its width is the clog2 of the larger of OPEN_CYCLES and LOCK_CYCLES.

Test Plan:
- Correct code: digits 1,2,3,4 in consecutive cycles → unlocked=1 two cycles after the 4th strobe. It stays high for 500 cycles, then locked=1.
- Wrong code three times: 1,2,3,5 ×3 → fail_cnt goes 1,2,3, then alarm=1. Digits during the 1000 lockout cycles are ignored. Afterwards alarm=0 and fail_cnt=0.
- Clear mid-entry: 1,2 then clear, then 1,2,3,4 → unlocked=1. fail_cnt stays 0 throughout. clear together with digit_vld also aborts the entry.
- Invalid digits: digit=4'hA or 4'hF strobed between valid digits → entry_cnt unchanged, and the correct code still unlocks.
- Relock and reset: relock in OPEN cycle 10 → locked=1 next cycle. rst_n low mid-lockout → alarm=0 immediately (asynchronous).
- With SAFE_REPROGRAM_EN: unlock, pulse prog, enter 9,8,7,6 → 1,2,3,4 then fails, and 9,8,7,6 unlocks.
